// File: rtl/rock_pkg.sv
// Shared lane state type, default geometry and LFSR constants for the rock field mover.
package rock_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_FALL    = 2'd1,
        ST_RESPAWN = 2'd2
    } lane_state_e;

    localparam int unsigned DEF_NUM_ROCKS    = 4;
    localparam int unsigned DEF_COORD_W      = 11;
    localparam int unsigned DEF_Y_LIMIT      = 770;
    localparam int unsigned DEF_Y_WRAP       = 760;
    localparam int unsigned DEF_Y_SPAWN_SPAN = 128;
    localparam int unsigned DEF_X_MIN        = 333;
    localparam int unsigned DEF_X_SPAN       = 512;
    localparam int unsigned DEF_X_HOP        = 248;

    // Galois form, taps 16,14,13,11, shifting right.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/rock_field_mover_if.sv
// Frame-tick / hit inputs and packed rock coordinate outputs of the rock field mover.
interface rock_field_mover_if
    import rock_pkg::*;
#(
    parameter int unsigned NUM_ROCKS = DEF_NUM_ROCKS,
    parameter int unsigned COORD_W   = DEF_COORD_W
) ();

    logic                           move;
    logic [2:0]                     speed;
    logic [NUM_ROCKS-1:0]           collision;
    logic [NUM_ROCKS-1:0]           planehit;
    logic [NUM_ROCKS*COORD_W-1:0]   init_x;
    logic [NUM_ROCKS*COORD_W-1:0]   init_y;
    logic [NUM_ROCKS*COORD_W-1:0]   ox;
    logic [NUM_ROCKS*COORD_W-1:0]   oy;
    logic [NUM_ROCKS-1:0]           respawned;
    logic [NUM_ROCKS-1:0]           plane_hit_evt;

    modport master (
        output move, speed, collision, planehit, init_x, init_y,
        input  ox, oy, respawned, plane_hit_evt
    );

    modport slave (
        input  move, speed, collision, planehit, init_x, init_y,
        output ox, oy, respawned, plane_hit_evt
    );

endinterface

// File: rtl/rock_lane.sv
// One falling rock: LOAD/FALL/RESPAWN FSM with its x/y registers and event pulses.
module rock_lane
    import rock_pkg::*;
#(
    parameter int unsigned COORD_W      = DEF_COORD_W,
    parameter int unsigned Y_LIMIT      = DEF_Y_LIMIT,
    parameter int unsigned Y_WRAP       = DEF_Y_WRAP,
    parameter int unsigned Y_SPAWN_SPAN = DEF_Y_SPAWN_SPAN,
    parameter int unsigned X_MIN        = DEF_X_MIN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               move,
    input  logic [2:0]         speed,
    input  logic               collision,
    input  logic               planehit,
    input  logic [COORD_W-1:0] init_x,
    input  logic [COORD_W-1:0] init_y,
    input  logic [COORD_W-1:0] new_x_off,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               respawned,
    output logic               plane_hit_evt
);

    lane_state_e        state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               respawned_q, respawned_d;
    logic               plane_hit_evt_q, plane_hit_evt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_LOAD;
            x_q             <= init_x;
            y_q             <= init_y;
            respawned_q     <= 1'b0;
            plane_hit_evt_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            x_q             <= x_d;
            y_q             <= y_d;
            respawned_q     <= respawned_d;
            plane_hit_evt_q <= plane_hit_evt_d;
        end
    end

    // Event flags are set on entry so they are high exactly during the RESPAWN cycle.
    always_comb begin
        state_d         = state_q;
        x_d             = x_q;
        y_d             = y_q;
        respawned_d     = 1'b0;
        plane_hit_evt_d = 1'b0;
        case (state_q)
            ST_LOAD: begin
                x_d     = init_x;
                y_d     = init_y;
                state_d = ST_FALL;
            end
            ST_FALL: begin
                if (move) begin
                    y_d = y_q + COORD_W'(speed);
                    if (collision || planehit || (y_q > COORD_W'(Y_LIMIT))) begin
                        state_d         = ST_RESPAWN;
                        respawned_d     = 1'b1;
                        plane_hit_evt_d = planehit;
                    end
                end
            end
            ST_RESPAWN: begin
                y_d     = (y_q - COORD_W'(Y_WRAP)) & COORD_W'(Y_SPAWN_SPAN - 1);
                x_d     = COORD_W'(X_MIN) + new_x_off;
                state_d = ST_FALL;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign x             = x_q;
    assign y             = y_q;
    assign respawned     = respawned_q;
    assign plane_hit_evt = plane_hit_evt_q;

endmodule

// File: rtl/rock_field_mover.sv
// NUM_ROCKS independent falling rocks. Define ROCK_LFSR_EN for pseudo-random respawn x,
// otherwise each respawn hops x by X_HOP within the window.
module rock_field_mover
    import rock_pkg::*;
#(
    parameter int unsigned NUM_ROCKS    = DEF_NUM_ROCKS,
    parameter int unsigned COORD_W      = DEF_COORD_W,
    parameter int unsigned Y_LIMIT      = DEF_Y_LIMIT,
    parameter int unsigned Y_WRAP       = DEF_Y_WRAP,
    parameter int unsigned Y_SPAWN_SPAN = DEF_Y_SPAWN_SPAN,
    parameter int unsigned X_MIN        = DEF_X_MIN,
    parameter int unsigned X_SPAN       = DEF_X_SPAN,
    parameter int unsigned X_HOP        = DEF_X_HOP
) (
    input logic               clk,
    input logic               rst,
    rock_field_mover_if.slave bus
);

    if (NUM_ROCKS < 1 || NUM_ROCKS > 16) begin : g_bad_num_rocks
        $error("NUM_ROCKS must be in 1..16");
    end
    if (Y_SPAWN_SPAN == 0 || (Y_SPAWN_SPAN & (Y_SPAWN_SPAN - 1)) != 0) begin : g_bad_y_span
        $error("Y_SPAWN_SPAN must be a power of two");
    end
    if (X_SPAN == 0 || (X_SPAN & (X_SPAN - 1)) != 0) begin : g_bad_x_span
        $error("X_SPAN must be a power of two");
    end

    logic [COORD_W-1:0] x_w [NUM_ROCKS];
    logic [COORD_W-1:0] y_w [NUM_ROCKS];

`ifdef ROCK_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end
`endif

    for (genvar i = 0; i < int'(NUM_ROCKS); i++) begin : g_lane
        logic [COORD_W-1:0] off_c;

`ifdef ROCK_LFSR_EN
        // Per-lane whitening so lanes respawning together land at different x.
        assign off_c = COORD_W'((lfsr_q ^ 16'(i * 32'h9E37)) & 16'(X_SPAN - 1));
`else
        assign off_c = COORD_W'((32'(x_w[i]) + 32'(X_HOP)) & 32'(X_SPAN - 1));
`endif

        rock_lane #(
            .COORD_W      (COORD_W),
            .Y_LIMIT      (Y_LIMIT),
            .Y_WRAP       (Y_WRAP),
            .Y_SPAWN_SPAN (Y_SPAWN_SPAN),
            .X_MIN        (X_MIN)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .move          (bus.move),
            .speed         (bus.speed),
            .collision     (bus.collision[i]),
            .planehit      (bus.planehit[i]),
            .init_x        (bus.init_x[i*COORD_W +: COORD_W]),
            .init_y        (bus.init_y[i*COORD_W +: COORD_W]),
            .new_x_off     (off_c),
            .x             (x_w[i]),
            .y             (y_w[i]),
            .respawned     (bus.respawned[i]),
            .plane_hit_evt (bus.plane_hit_evt[i])
        );

        assign bus.ox[i*COORD_W +: COORD_W] = x_w[i];
        assign bus.oy[i*COORD_W +: COORD_W] = y_w[i];
    end

endmodule

// File: tb/tb_rock_field_mover.sv
// Bench for rock_field_mover: per-cycle model comparison plus directed literal checks.
// With ROCK_LFSR_EN defined it also models the LFSR and checks the respawn window.
module tb_rock_field_mover;

    localparam int NR      = 4;
    localparam int CW      = 11;
    localparam int Y_LIMIT = 770;
    localparam int Y_WRAP  = 760;
    localparam int Y_SPAN  = 128;
    localparam int X_MIN   = 333;
    localparam int X_SPAN  = 512;
    localparam int X_HOP   = 248;
    localparam int MODW    = 2048;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rock_field_mover_if #(.NUM_ROCKS(NR), .COORD_W(CW)) bus ();

    rock_field_mover #(.NUM_ROCKS(NR), .COORD_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: coordinates as plain ints, a pending-respawn flag and its cause.
    int mx [NR];
    int my [NR];
    bit m_loading [NR];
    bit m_pending [NR];
    bit m_by_plane [NR];
    bit m_valid = 1'b0;
    int pcnt [NR];
    int phcnt [NR];
`ifdef ROCK_LFSR_EN
    logic [15:0] mlfsr;
`endif

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int lane_of(input logic [NR*CW-1:0] v, input int i);
        return 32'(v[i*CW +: CW]);
    endfunction

    function automatic int respawn_off(input int i);
`ifdef ROCK_LFSR_EN
        return int'(mlfsr ^ 16'(i * 40503)) % X_SPAN;
`else
        return (mx[i] + X_HOP) % X_SPAN;
`endif
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (rst) begin
                mx[i] = lane_of(bus.init_x, i);
                my[i] = lane_of(bus.init_y, i);
                m_loading[i] = 1'b1;
                m_pending[i] = 1'b0;
                m_by_plane[i] = 1'b0;
            end else if (m_loading[i]) begin
                mx[i] = lane_of(bus.init_x, i);
                my[i] = lane_of(bus.init_y, i);
                m_loading[i] = 1'b0;
            end else if (m_pending[i]) begin
                my[i] = ((my[i] - Y_WRAP + MODW) % MODW) % Y_SPAN;
                mx[i] = X_MIN + respawn_off(i);
                m_pending[i] = 1'b0;
                m_by_plane[i] = 1'b0;
            end else if (bus.move) begin
                bit hit;
                hit = bus.collision[i] || bus.planehit[i] || (my[i] > Y_LIMIT);
                my[i] = (my[i] + int'(bus.speed)) % MODW;
                if (hit) begin
                    m_pending[i] = 1'b1;
                    m_by_plane[i] = bus.planehit[i];
                end
            end
        end
`ifdef ROCK_LFSR_EN
        if (rst) mlfsr = 16'hACE1;
        else begin
            bit fb;
            fb = mlfsr[0];
            mlfsr = mlfsr >> 1;
            if (fb) mlfsr = mlfsr ^ (16'h8000 | 16'h2000 | 16'h1000 | 16'h0400);
        end
`endif
        if (rst) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("model_ox[%0d]", i), lane_of(bus.ox, i), mx[i]);
                chk($sformatf("model_oy[%0d]", i), lane_of(bus.oy, i), my[i]);
                chk($sformatf("model_respawned[%0d]", i), int'(bus.respawned[i]), int'(m_pending[i]));
                chk($sformatf("model_plane_hit_evt[%0d]", i), int'(bus.plane_hit_evt[i]),
                    int'(m_pending[i] && m_by_plane[i]));
                if (bus.respawned[i]) pcnt[i]++;
                if (bus.plane_hit_evt[i]) phcnt[i]++;
            end
        end
    end

    task automatic tick(input logic [NR-1:0] c, input logic [NR-1:0] p);
        @(negedge clk);
        bus.move = 1'b1; bus.collision = c; bus.planehit = p;
        @(negedge clk);
        bus.move = 1'b0; bus.collision = '0; bus.planehit = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input int ex [NR], input int ey [NR]);
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            bus.init_x[i*CW +: CW] = CW'(ex[i]);
            bus.init_y[i*CW +: CW] = CW'(ey[i]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("reset_oy[%0d]", i), lane_of(bus.oy, i), ey[i]);
            chk($sformatf("reset_ox[%0d]", i), lane_of(bus.ox, i), ex[i]);
        end
        chk("reset_respawned", int'(bus.respawned), 0);
        repeat (2) @(negedge clk);
        chk("after_load_respawned", int'(bus.respawned), 0);
    endtask

    initial begin
        int ex [NR];
        int ey1 [NR];
        int ey2 [NR];
        int p0, p1, p2, p3, ph1, ph2, psum;

        ex  = '{333, 50, 60, 70};
        ey1 = '{100, 200, 300, 400};
        ey2 = '{771, 200, 300, 768};
        bus.move = 1'b0; bus.speed = 3'd0; bus.collision = '0; bus.planehit = '0;
        bus.init_x = '0; bus.init_y = '0;
        for (int i = 0; i < NR; i++) begin pcnt[i] = 0; phcnt[i] = 0; end

        do_reset(ex, ey1);

        bus.speed = 3'd2;
        repeat (10) tick('0, '0);
        chk("fall_y0", lane_of(bus.oy, 0), 120);
        chk("fall_y3", lane_of(bus.oy, 3), 420);
        bus.speed = 3'd0;
        repeat (3) tick('0, '0);
        chk("freeze_y0", lane_of(bus.oy, 0), 120);

        // Off-screen respawn on lane 0, and the Y_LIMIT boundary on lane 3.
        do_reset(ex, ey2);
        bus.speed = 3'd2;
        p0 = pcnt[0]; p3 = pcnt[3];
        tick('0, '0);
        chk("offscreen_y0", lane_of(bus.oy, 0), 13);
        chk("offscreen_x0", lane_of(bus.ox, 0), 402);
        chk("offscreen_pulse0", pcnt[0] - p0, 1);
        chk("limit_y3_770", lane_of(bus.oy, 3), 770);
        tick('0, '0);
        chk("limit_y3_772", lane_of(bus.oy, 3), 772);
        chk("limit_no_pulse3", pcnt[3] - p3, 0);
        tick('0, '0);
        chk("limit_pulse3", pcnt[3] - p3, 1);
        chk("limit_y3_respawn", lane_of(bus.oy, 3), 14);
        chk("limit_x3_respawn", lane_of(bus.ox, 3), 651);

        // Hits without move are ignored.
        p1 = pcnt[1];
        @(negedge clk); bus.collision = 4'b0010;
        repeat (2) @(negedge clk);
        bus.collision = '0;
        repeat (2) @(negedge clk);
        chk("hit_no_move1", pcnt[1] - p1, 0);

        p1 = pcnt[1]; ph1 = phcnt[1];
        tick(4'b0010, 4'b0000);
        chk("shot_pulse1", pcnt[1] - p1, 1);
        chk("shot_plane_evt1", phcnt[1] - ph1, 0);

        p2 = pcnt[2]; ph2 = phcnt[2];
        tick(4'b0100, 4'b0100);
        chk("both_pulse2", pcnt[2] - p2, 1);
        chk("both_plane_evt2", phcnt[2] - ph2, 1);

        // Reset sampled together with hits aborts the respawn without pulses.
        psum = pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3];
        @(negedge clk);
        rst = 1'b1; bus.move = 1'b1; bus.collision = '1; bus.planehit = '1;
        @(negedge clk);
        rst = 1'b0; bus.move = 1'b0; bus.collision = '0; bus.planehit = '0;
        chk("abort_y0", lane_of(bus.oy, 0), 771);
        chk("abort_y3", lane_of(bus.oy, 3), 768);
        chk("abort_x1", lane_of(bus.ox, 1), 50);
        repeat (4) @(negedge clk);
        chk("abort_no_pulse", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] - psum, 0);

`ifdef ROCK_LFSR_EN
        bus.speed = 3'd1;
        repeat (64) begin
            @(negedge clk); bus.move = 1'b1; bus.collision = '1;
            @(negedge clk); bus.move = 1'b0; bus.collision = '0;
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                int xv;
                xv = lane_of(bus.ox, i);
                chk($sformatf("lfsr_x_range[%0d]", i), int'(xv >= 333 && xv <= 844), 1);
                for (int j = i + 1; j < NR; j++)
                    chk($sformatf("lfsr_lanes_differ[%0d,%0d]", i, j),
                        int'(xv != lane_of(bus.ox, j)), 1);
            end
        end
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rock_field_mover.md
# rock_field_mover

Parametrised multi-rock successor to the single-rock mover for the DE1-SoC arcade plane game. Owns `NUM_ROCKS` independent falling rocks. Each rock loads a start position, falls by a programmable step on every `move` frame tick, and respawns near the top of the playfield when it is shot, hits the plane, or leaves the screen. Sits between the frame-tick generator and collision detector on one side and the sprite renderer on the other, and reports per-rock respawn and plane-hit events to score/lives logic.

## Interface
Parameters:
- `NUM_ROCKS`, 4: number of rock lanes (1..16).
- `COORD_W`, 11: coordinate width in bits.
- `Y_LIMIT`, 770: rock respawns once y exceeds this value.
- `Y_WRAP`, 760: offset subtracted from y when computing the respawn y.
- `Y_SPAWN_SPAN`, 128: respawn y range; must be a power of two.
- `X_MIN`, 333: left edge of the respawn window.
- `X_SPAN`, 512: respawn x range; must be a power of two.
- `X_HOP`, 248: x increment per respawn (deterministic mode only).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `move` in 1: frame tick, one cycle wide.
- `speed` in 3: y step per tick. 0 freezes all rocks.
- `collision` in NUM_ROCKS: per-rock bullet hit.
- `planehit` in NUM_ROCKS: per-rock plane hit.
- `init_x`, `init_y` in NUM_ROCKS*COORD_W: start coordinates, packed with lane 0 in the LSBs.
- `ox`, `oy` out NUM_ROCKS*COORD_W: current coordinates, same packing.
- `respawned` out NUM_ROCKS: one-cycle pulse in each lane's RESPAWN cycle.
- `plane_hit_evt` out NUM_ROCKS: one-cycle pulse when a respawn was caused by `planehit`.

## Operation
- Each lane runs its own FSM with three states: LOAD, FALL, RESPAWN. The reset state is LOAD.
- **LOAD**: x/y ← `init_x`/`init_y` slice. Go to FALL.
- **FALL**: when `move`=1:
  - y ← y + `speed`, zero-extended, modulo 2^COORD_W.
  - If `collision[i]`, `planehit[i]`, or the current y (pre-increment) > `Y_LIMIT`, go to RESPAWN. The increment still applies in that cycle.
  - When `move`=0, hold position. Hit inputs are ignored while `move`=0.
- **RESPAWN**:
  - y ← ((y − Y_WRAP) mod 2^COORD_W) mod Y_SPAWN_SPAN.
  - x ← X_MIN + new_x_offset (see Configuration).
  - Assert `respawned[i]`. Assert `plane_hit_evt[i]` if `planehit[i]` caused the exit from FALL; this flag is latched when leaving FALL.
  - Go to FALL. `move` is ignored in this cycle.
- Simultaneous `collision` and `planehit` cause one respawn, with `plane_hit_evt` asserted.
- An out-of-encoding state returns to LOAD on the next cycle.
- Lanes are fully independent. Any mix of lanes may respawn in the same cycle.

## Timing
- Reset is synchronous. In the cycle `rst` is sampled high, all lanes load the `init_*` values and `ox`/`oy` equal `init_x`/`init_y` in the following cycle. `respawned`=0 and `plane_hit_evt`=0 during reset.
- Asserting `rst` mid-operation aborts FALL or RESPAWN with no event pulses.
- First movement happens no earlier than 2 cycles after `rst` deasserts (one LOAD cycle, then FALL).
- Outputs are registered. A position change is visible 1 cycle after the `move` sample.
- Respawn latency: the hit is sampled with `move`, RESPAWN occurs on the next cycle, and the new coordinates appear on the cycle after that.
- `move` must be spaced at least 2 cycles apart to guarantee no tick is lost to a RESPAWN cycle.

## Configuration
- `ROCK_LFSR_EN` defined:
  - One shared 16-bit Galois LFSR (taps 16,14,13,11), seeded to 16'hACE1 on `rst`, advancing every cycle.
  - Lane i's offset = (lfsr ^ (i * 16'h9E37)) mod X_SPAN.
- `ROCK_LFSR_EN` undefined:
  - Deterministic offset = (x + X_HOP) mod X_SPAN.
  - No LFSR is instantiated.

## Structure
- Package `rock_pkg`:
  - lane state enum (LOAD, FALL, RESPAWN);
  - default coordinate constants;
  - the LFSR seed and tap mask.
- Sub-module `rock_lane`: one FSM with its x/y registers, instantiated NUM_ROCKS times in a generate loop.
- The top level holds the shared LFSR, packs and unpacks the coordinate buses, and checks the power-of-two parameters with elaboration-time assertions.

## Test plan
- **Reset load**: NUM_ROCKS=4, init_y = {100, 200, 300, 400}, pulse `rst` → next cycle `oy` matches init_y; after LOAD, `respawned`=0.
- **Fall**: `speed`=2, 10 `move` ticks spaced 4 cycles apart → lane 0 y goes 100 → 120; `speed`=0 → y frozen.
- **Off-screen respawn**: lane y=771, `move` → RESPAWN → y = (773 − 760) mod 128 = 13. Deterministic build with x=333 → x = 333 + (581 mod 512) = 402.
- **Shot vs plane hit**:
  - `collision[1]`+`move` → `respawned[1]` pulses and `plane_hit_evt[1]`=0.
  - `planehit[2]` and `collision[2]` together → a single `respawned[2]` pulse and `plane_hit_evt[2]`=1.
- **Mid-RESPAWN reset**: assert `rst` during a lane's RESPAWN → no pulse, and all lanes return to init values.
- **LFSR build**: with `ROCK_LFSR_EN`, 64 respawns per lane → every x in [333, 844], and lanes differ in the same cycle.
